// File: rtl/delay_rx_buffer.sv
// delay_rx_buffer
//   Receiving end of a fixed-latency upstream delay line that has no backpressure.
//   Upstream may launch a word only while credit is available (issue_ready_o).
//   Words emerge DELAY_BY cycles later on data_valid_i/data_i. They are captured
//   in a DEPTH-entry FIFO and drained through a valid/ready handshake, so the
//   downstream pipeline can stall without losing words still in flight.
//
//   Optional build macro: DELAY_RX_BUFFER_BYPASS_EN
//     When it is defined, an arriving word is presented on valid_o/data_o in the
//     same cycle if the FIFO is empty. If ready_i is also high, the word is consumed
//     directly and is never written into the FIFO.
//
// Ports
//   clk_i          clock, all state on posedge
//   arstn_i        asynchronous reset, active-low
//   issue_valid_i  upstream wants to launch a word this cycle
//   issue_ready_o  credit available (decoded from the credit register only)
//   data_valid_i   word emerging from the delay line
//   data_i         emerging word
//   valid_o        FIFO head valid
//   data_o         FIFO head data
//   ready_i        downstream accepts head
//   overflow_o     sticky: word arrived while FIFO full
module delay_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DELAY_BY   = 2,
    parameter int DEPTH      = DELAY_BY + 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic                  overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Reject configurations that cannot work.
    generate
        if (DEPTH < 1 || DELAY_BY < 1) begin : g_bad_cfg
            $error("delay_rx_buffer: DEPTH and DELAY_BY must both be >= 1");
        end
    endgenerate

    logic [CW-1:0]         credit_cnt;
    logic [CW-1:0]         fill;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] storage [DEPTH];

    logic issue;
    logic pop;
    logic fifo_pop;
    logic wr;
    logic full;
    logic empty;
    logic bypass;

    assign full          = (fill == DEPTH_C);
    assign empty         = (fill == '0);
    assign issue_ready_o = (credit_cnt < DEPTH_C);
    assign issue         = issue_valid_i && issue_ready_o;

`ifdef DELAY_RX_BUFFER_BYPASS_EN
    // An empty FIFO forwards the arriving word straight to the head.
    assign bypass  = empty && data_valid_i;
    assign valid_o = !empty || data_valid_i;
    assign data_o  = bypass ? data_i : storage[rd_ptr];
`else
    assign bypass  = 1'b0;
    assign valid_o = !empty;
    assign data_o  = storage[rd_ptr];
`endif

    assign pop      = valid_o && ready_i;
    assign fifo_pop = !empty && ready_i;
    // A full FIFO never accepts a write, even if it pops in the same cycle.
    assign wr       = data_valid_i && !full && !(bypass && ready_i);

    // Credits track words that have been issued and not yet popped, whether they are in flight or stored.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            credit_cnt <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credit_cnt <= credit_cnt + CW'(1);
                2'b01:   credit_cnt <= credit_cnt - CW'(1);
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Occupancy counter, which is separate from the pointers so that non-power-of-2 depths work.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            fill <= '0;
        end else begin
            case ({wr, fifo_pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Pointers wrap at DEPTH-1.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Storage array, which is cleared on reset so that data_o reads 0 afterwards.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (wr) begin
            storage[wr_ptr] <= data_i;
        end
    end

    // Sticky overflow flag: a word arrived while there was no room for it.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            overflow_o <= 1'b0;
        end else if (data_valid_i && full) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_delay_rx_buffer.sv
// tb_delay_rx_buffer
//   Randomized self-checking bench for delay_rx_buffer. The bench provides the
//   upstream delay line itself. A reference model predicts every output in every
//   cycle from a queue of stored words plus the contents of the delay line.
//   Credit in use = words in the line + words stored.
module tb_delay_rx_buffer;

    localparam int DW       = 8;
    localparam int DELAY_BY = 2;
    localparam int DEPTH    = DELAY_BY + 1;

    logic          clk;
    logic          arstn;
    logic          issue_valid;
    logic          issue_ready;
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          ready;
    logic          overflow;

    delay_rx_buffer #(
        .DATA_WIDTH (DW),
        .DELAY_BY   (DELAY_BY),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .data_valid_i  (data_valid),
        .data_i        (data_in),
        .valid_o       (valid),
        .data_o        (data_out),
        .ready_i       (ready),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state
    logic [DW-1:0] q[$];
    bit            line_v [DELAY_BY];
    logic [DW-1:0] line_d [DELAY_BY];
    bit            exp_ovf;
    bit            last_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < DELAY_BY; k++) begin
            line_v[k] = 1'b0;
            line_d[k] = '0;
        end
        exp_ovf = 1'b0;
    endtask

    // One clock cycle: drive, check, then advance the model across the edge.
    task automatic step(input bit iv, input bit rdy, input logic [DW-1:0] word,
                        input bit force_aa, output bit accepted);
        bit            dv;
        logic [DW-1:0] dd;
        bit            exp_v;
        logic [DW-1:0] exp_d;
        bit            exp_rdy;
        bit            byp;
        bit            wr;
        bit            pop;
        int            in_line;
        @(negedge clk);
        dv = line_v[DELAY_BY-1];
        dd = line_d[DELAY_BY-1];
        if (force_aa) begin
            dv = 1'b1;
            dd = 8'hAA;
        end
        issue_valid = iv;
        ready       = rdy;
        data_valid  = dv;
        data_in     = dd;
        #1;
        in_line = 0;
        for (int k = 0; k < DELAY_BY; k++) in_line += int'(line_v[k]);
        exp_rdy = (in_line + q.size()) < DEPTH;
        exp_v   = (q.size() != 0);
        exp_d   = exp_v ? q[0] : '0;
`ifdef DELAY_RX_BUFFER_BYPASS_EN
        byp = (q.size() == 0) && dv;
        if (byp) begin
            exp_v = 1'b1;
            exp_d = dd;
        end
`else
        byp = 1'b0;
`endif
        check("valid", 32'(valid), 32'(exp_v));
        if (exp_v) check("data", 32'(data_out), 32'(exp_d));
        check("issue_ready", 32'(issue_ready), 32'(exp_rdy));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        last_valid = valid;

        accepted = iv && exp_rdy;
        pop      = exp_v && rdy;
        wr       = dv && (q.size() < DEPTH) && !(byp && rdy);
        if (dv && q.size() == DEPTH) exp_ovf = 1'b1;
        if (pop && !byp) void'(q.pop_front());
        if (wr) q.push_back(dd);
        for (int k = DELAY_BY - 1; k > 0; k--) begin
            line_v[k] = line_v[k-1];
            line_d[k] = line_d[k-1];
        end
        line_v[0] = accepted;
        line_d[0] = word;
    endtask

    // Asynchronous reset that lands between clock edges.
    task automatic async_reset();
        @(negedge clk);
        #2;
        arstn       = 1'b0;
        issue_valid = 1'b0;
        data_valid  = 1'b0;
        ready       = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    // Measure the number of cycles from a single issue until valid_o first rises.
    task automatic latency_test(input logic [DW-1:0] word);
        bit acc;
        int lat;
        lat = 0;
        step(1'b1, 1'b1, word, 1'b0, acc);
        check("lat_issue_acc", 32'(acc), 32'd1);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, acc);
            if (last_valid) lat = i;
        end
`ifdef DELAY_RX_BUFFER_BYPASS_EN
        check("latency", 32'(lat), 32'(DELAY_BY));
`else
        check("latency", 32'(lat), 32'(DELAY_BY + 1));
`endif
    endtask

    initial begin
        bit            acc;
        int            n_acc;
        logic [DW-1:0] word;

        arstn       = 1'b0;
        issue_valid = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        ready       = 1'b0;
        last_valid  = 1'b0;
        model_clear();
        #12;
        check("init_valid", 32'(valid), 32'd0);
        check("init_data", 32'(data_out), 32'd0);
        check("init_issue_ready", 32'(issue_ready), 32'd1);
        check("init_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        latency_test(8'h5A);
        repeat (4) step(1'b0, 1'b1, 8'h00, 1'b0, acc);

        // Streaming of 0x01..0x20 with ready held high
        word  = 8'h01;
        n_acc = 0;
        for (int i = 0; i < 200 && n_acc < 32; i++) begin
            step(1'b1, 1'b1, word, 1'b0, acc);
            if (acc) begin
                n_acc++;
                word = word + 8'h01;
            end
        end
        check("stream_count", 32'(n_acc), 32'd32);
        repeat (6) step(1'b0, 1'b1, 8'h00, 1'b0, acc);

        // Stall: at most DEPTH words may be in flight or stored
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, acc);
            if (acc) n_acc++;
        end
        check("stall_count", 32'(n_acc), 32'(DEPTH));
        check("stall_fill", 32'(q.size()), 32'(DEPTH));
        repeat (8) step(1'b0, 1'b1, 8'h00, 1'b0, acc);

        // Random traffic that exercises pointer wrap and simultaneous issue and pop
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 8'($urandom), 1'b0, acc);
        end

        // Overflow: fill the FIFO completely, then inject 0xAA
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, acc);
        check("ovf_pre_full", 32'(q.size()), 32'(DEPTH));
        step(1'b0, 1'b0, 8'h00, 1'b1, acc);
        step(1'b0, 1'b0, 8'h00, 1'b0, acc);
        check("ovf_set", 32'(overflow), 32'd1);
        repeat (8) step(1'b0, 1'b1, 8'h00, 1'b0, acc);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Mid-traffic reset, followed by a fresh latency check
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0, acc);
        async_reset();
        latency_test(8'h55);
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'b0, acc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
